// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus arbiter: FSM states,
// default pointer width and the requester data slice selector.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int PTR_W       = $clog2(NUM_REQ_DEF);

    // Upper bounds for the flattened request bus and a single slice.
    localparam int FLAT_MAX  = 1024;
    localparam int SLICE_MAX = 64;

    // Returns requester idx's data; the caller truncates to its DATA_W.
    function automatic logic [SLICE_MAX-1:0] data_slice(
        input logic [FLAT_MAX-1:0] flat,
        input int                  idx,
        input int                  width
    );
        logic [FLAT_MAX-1:0] shifted;
        shifted = flat >> (idx * width);
        return shifted[SLICE_MAX-1:0];
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational rotate-priority search: the first set request strictly
// after last_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      last_ptr,
    output logic               found,
    output logic [PW-1:0]      idx,
    output logic [NUM_REQ-1:0] onehot
);

    // Walk candidates farthest-first so the nearest set request wins last.
    always_comb begin
        logic [PW-1:0] cand_s;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand_s = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = PW'((int'(last_ptr) + k) % NUM_REQ);
            if (req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin single-driver bus stage with bounded bursts, a turnaround
// cycle between owners and charge-retention (held/stale) modelling.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_BURST   = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      bus_en,
    output logic                      bus_valid,
    output logic                      bus_held,
    output logic                      bus_stale,
    output logic                      busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);

    state_e              state_r,     state_s;
    logic [NUM_REQ-1:0]  grant_r,     grant_s;
    logic [PW-1:0]       gidx_r,      gidx_s;
    logic [PW-1:0]       last_ptr_r,  last_ptr_s;
    logic [BW-1:0]       beat_cnt_r,  beat_cnt_s;
    logic [HW-1:0]       hold_cnt_r,  hold_cnt_s;
    logic [DATA_W-1:0]   bus_data_r,  bus_data_s;
    logic                bus_en_r,    bus_en_s;
    logic                bus_valid_r, bus_valid_s;
    logic                bus_held_r,  bus_held_s;
    logic                bus_stale_r, bus_stale_s;
    logic                busy_r,      busy_s;

    logic                beat_s;
    logic                pick_found_s;
    logic [PW-1:0]       pick_idx_s;
    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [FLAT_MAX-1:0] flat_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s),
        .onehot   (pick_onehot_s)
    );

    // Widen the request data so the package slice helper can index it.
    always_comb begin
        flat_s = '0;
        flat_s[NUM_REQ*DATA_W-1:0] = req_data;
    end

    // Next-state, beat and hold/charge logic.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        gidx_s     = gidx_r;
        last_ptr_s = last_ptr_r;
        beat_cnt_s = beat_cnt_r;
        bus_data_s = bus_data_r;
        beat_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    grant_s    = pick_onehot_s;
                    gidx_s     = pick_idx_s;
                    beat_cnt_s = '0;
                    state_s    = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (req[gidx_r]) begin
                    beat_s     = 1'b1;
                    bus_data_s = DATA_W'(data_slice(flat_s, int'(gidx_r), DATA_W));
                    beat_cnt_s = beat_cnt_r + BW'(1);
                    if (req_last[gidx_r] || (beat_cnt_r == BEAT_LAST)) begin
                        grant_s    = '0;
                        last_ptr_s = gidx_r;
                        state_s    = TURN;
                    end else begin
                        state_s = DRIVE;
                    end
                end else begin
                    // Owner withdrew: release without a beat.
                    grant_s    = '0;
                    last_ptr_s = gidx_r;
                    state_s    = TURN;
                end
            end
            TURN: begin
                grant_s = '0;
                state_s = IDLE;
            end
            default: begin
                grant_s = '0;
                state_s = IDLE;
            end
        endcase

        // Charge retention: any edge without a beat ages the held value.
        if (beat_s) begin
            hold_cnt_s  = '0;
            bus_stale_s = 1'b0;
        end else begin
            hold_cnt_s  = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + HW'(1);
            bus_stale_s = bus_stale_r | (hold_cnt_s == HOLD_MAX);
        end

        bus_en_s    = beat_s;
        bus_valid_s = beat_s;
        bus_held_s  = ~beat_s;
        busy_s      = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            gidx_r      <= '0;
            last_ptr_r  <= PTR_RESET;
            beat_cnt_r  <= '0;
            hold_cnt_r  <= HOLD_MAX;
            bus_data_r  <= '0;
            bus_en_r    <= 1'b0;
            bus_valid_r <= 1'b0;
            bus_held_r  <= 1'b1;
            bus_stale_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            gidx_r      <= gidx_s;
            last_ptr_r  <= last_ptr_s;
            beat_cnt_r  <= beat_cnt_s;
            hold_cnt_r  <= hold_cnt_s;
            bus_data_r  <= bus_data_s;
            bus_en_r    <= bus_en_s;
            bus_valid_r <= bus_valid_s;
            bus_held_r  <= bus_held_s;
            bus_stale_r <= bus_stale_s;
            busy_r      <= busy_s;
        end
    end

    assign grant     = grant_r;
    assign bus_data  = bus_data_r;
    assign bus_en    = bus_en_r;
    assign bus_valid = bus_valid_r;
    assign bus_held  = bus_held_r;
    assign bus_stale = bus_stale_r;
    assign busy      = busy_r;

endmodule
